// File: rtl/cpu_sequencer.sv
// Purpose : fetch/execute controller for the 4-bit CPU; owns PC and carry flag.
// Latency : 2 cycles/instruction with a same-cycle ROM ack, +1 per ROM wait cycle.
// Backpr.  : ROM stalls hold FETCH (rom_req high) until rom_ack or timeout -> sticky FAULT.
//
// Ports:
//   clk_cpu, reset          clock, synchronous active-high reset
//   run, step               free-run enable / single-instruction pulse (honoured in IDLE only)
//   rom_req, rom_addr       fetch request (registered) and address (= pc register)
//   rom_ack, rom_data       ROM response; rom_data = {op, imm}
//   op_out, im_out          decoded fields, held until the next successful fetch
//   exec_en                 one-cycle execute strobe
//   carry_in, carry_flag    ALU carry-out sampled on exec_en / registered carry flag
//   fault, state_out        sticky ROM-timeout flag / debug state (0 IDLE,1 FETCH,2 EXEC,3 FAULT)

`ifndef OP_NOP
`define OP_NOP 4'h0
`endif
`ifndef OP_JMP
`define OP_JMP 4'hE
`endif
`ifndef OP_JNC
`define OP_JNC 4'hF
`endif

module cpu_sequencer #(
  parameter int PC_W        = 4,
  parameter int ROM_TIMEOUT = 8
) (
  input  logic            clk_cpu,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  output logic [3:0]      op_out,
  output logic [3:0]      im_out,
  output logic            exec_en,
  input  logic            carry_in,
  output logic            carry_flag,
  output logic            fault,
  output logic [1:0]      state_out
);

  localparam int CNT_W = $clog2(ROM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [3:0]        op_q, op_d;
  logic [3:0]        im_q, im_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rom_req_q, rom_req_d;
  logic              exec_en_q, exec_en_d;
  logic              fault_q, fault_d;
  logic              is_branch;
  logic              take_jump;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    im_d       = im_q;
    carry_d    = carry_q;
    wait_cnt_d = wait_cnt_q;
    is_branch  = (op_q == `OP_JMP) || (op_q == `OP_JNC);
    // JNC looks at the flag as it stood before this instruction's update.
    take_jump  = (op_q == `OP_JMP) || ((op_q == `OP_JNC) && !carry_q);

    case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // An ack in the last allowed wait cycle still completes the fetch.
        if (rom_ack) begin
          op_d       = rom_data[7:4];
          im_d       = rom_data[3:0];
          wait_cnt_d = '0;
          state_d    = ST_EXEC;
        end else if (wait_cnt_q == CNT_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_EXEC: begin
        pc_d    = take_jump ? PC_W'(im_q) : pc_q + 1'b1;
        carry_d = is_branch ? 1'b0 : carry_in;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs are decoded from the state being entered so they
    // line up with state_q on the following cycle.
    rom_req_d = (state_d == ST_FETCH);
    exec_en_d = (state_d == ST_EXEC);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      op_q       <= `OP_NOP;
      im_q       <= '0;
      carry_q    <= 1'b0;
      wait_cnt_q <= '0;
      rom_req_q  <= 1'b0;
      exec_en_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      im_q       <= im_d;
      carry_q    <= carry_d;
      wait_cnt_q <= wait_cnt_d;
      rom_req_q  <= rom_req_d;
      exec_en_q  <= exec_en_d;
      fault_q    <= fault_d;
    end
  end

  assign rom_req    = rom_req_q;
  assign rom_addr   = pc_q;
  assign op_out     = op_q;
  assign im_out     = im_q;
  assign exec_en    = exec_en_q;
  assign carry_flag = carry_q;
  assign fault      = fault_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose : self-checking bench for cpu_sequencer with a behavioural ROM and a scoreboard.
// Latency : ROM ack delay programmable per test (0 = same cycle, large = never).
// Backpr.  : expected fetches are queued before each run and popped on every exec_en.

module tb_cpu_sequencer;

  localparam int PC_W        = 4;
  localparam int ROM_TIMEOUT = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h2;   // ADD_A_IM
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_JNC = 4'hF;

  logic            clk_cpu = 1'b0;
  logic            reset;
  logic            run;
  logic            step;
  logic            rom_req;
  logic [PC_W-1:0] rom_addr;
  logic            rom_ack;
  logic [7:0]      rom_data;
  logic [3:0]      op_out;
  logic [3:0]      im_out;
  logic            exec_en;
  logic            carry_in;
  logic            carry_flag;
  logic            fault;
  logic [1:0]      state_out;

  cpu_sequencer #(.PC_W(PC_W), .ROM_TIMEOUT(ROM_TIMEOUT)) dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .op_out     (op_out),
    .im_out     (im_out),
    .exec_en    (exec_en),
    .carry_in   (carry_in),
    .carry_flag (carry_flag),
    .fault      (fault),
    .state_out  (state_out)
  );

  always #5 clk_cpu = ~clk_cpu;

  // ---------------- behavioural ROM ----------------
  logic [7:0] rom_mem [16];
  int         ack_delay;
  logic       ack_force;
  int         wcnt;

  assign rom_data = rom_mem[rom_addr];
  assign rom_ack  = ack_force || (rom_req && (wcnt >= ack_delay));

  always @(posedge clk_cpu) begin
    if (rom_req && !rom_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0] addr;
    logic [3:0] op;
    logic [3:0] im;
    logic       carry;   // carry_flag value seen during this EXEC
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] fetch_addr = '0;

  task automatic push_exp(input int a, input logic c);
    exp_t e;
    e.addr  = 4'(a);
    e.op    = rom_mem[a][7:4];
    e.im    = rom_mem[a][3:0];
    e.carry = c;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_cpu) begin
    if (rom_req && rom_ack) fetch_addr = rom_addr;
    if (exec_en) begin
      if (sb_q.size() == 0) begin
        check_eq("exec_unexpected", int'(exec_en), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_addr",  int'(fetch_addr), int'(e.addr));
        check_eq("sb_op",    int'(op_out),     int'(e.op));
        check_eq("sb_im",    int'(im_out),     int'(e.im));
        check_eq("sb_carry", int'(carry_flag), int'(e.carry));
        check_eq("sb_state", int'(state_out),  2);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk_cpu);
    reset = 1'b0;
    sb_q.delete();
  endtask

  // Free-run until n_exec instructions executed; optionally checks the gap
  // between consecutive exec_en strobes. run is dropped in the last EXEC.
  task automatic run_prog(input int n_exec, input int gap, output int req_n);
    int got  = 0;
    int cyc  = 0;
    int last = 0;
    req_n = 0;
    run = 1'b1;
    while (got < n_exec && cyc < 400) begin
      @(negedge clk_cpu);
      cyc++;
      if (rom_req) req_n++;
      if (exec_en) begin
        got++;
        if (gap > 0 && got > 1) check_eq("exec_gap", cyc - last, gap);
        last = cyc;
        if (got == n_exec) run = 1'b0;
      end
    end
    run = 1'b0;
    check_eq("exec_count", got, n_exec);
  endtask

  // One step pulse, then watch a fixed window. Optionally re-pulses step
  // during the EXEC cycle (must be ignored).
  task automatic step_once(input int window, input bit repulse,
                           output int n_exec, output int req_n,
                           output int ack_cyc, output int exec_cyc);
    n_exec = 0; req_n = 0; ack_cyc = -1; exec_cyc = -1;
    step = 1'b1;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk_cpu);
      if (step) step = 1'b0;
      if (rom_req) req_n++;
      if (rom_req && rom_ack && ack_cyc < 0) ack_cyc = c;
      if (exec_en) begin
        n_exec++;
        if (exec_cyc < 0) exec_cyc = c;
        if (repulse && n_exec == 1) step = 1'b1;
      end
    end
    step = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_n, n_exec, ack_cyc, exec_cyc, cyc;
    logic [3:0] c3 [10];
    int a3 [10];

    reset = 1'b1; run = 1'b1; step = 1'b0; carry_in = 1'b0;
    ack_delay = 0; ack_force = 1'b0;
    for (int i = 0; i < 16; i++) rom_mem[i] = {OP_ADD, 4'd3};

    // ---- 1: reset held 2 cycles with run=1
    repeat (2) @(negedge clk_cpu);
    check_eq("rst_pc",      int'(rom_addr),   0);
    check_eq("rst_op",      int'(op_out),     int'(OP_NOP));
    check_eq("rst_im",      int'(im_out),     0);
    check_eq("rst_exec_en", int'(exec_en),    0);
    check_eq("rst_rom_req", int'(rom_req),    0);
    check_eq("rst_fault",   int'(fault),      0);
    check_eq("rst_carry",   int'(carry_flag), 0);
    check_eq("rst_state",   int'(state_out),  0);
    reset = 1'b0;

    // ---- 2: free run, same-cycle ack, address wrap 15 -> 0
    for (int a = 0; a < 16; a++) push_exp(a, 1'b0);
    push_exp(0, 1'b0);
    run_prog(17, 2, req_n);
    @(negedge clk_cpu);
    check_eq("wrap_pc_after", int'(rom_addr),  1);
    check_eq("wrap_idle",     int'(state_out), 0);

    // ---- 3: JMP / JNC with carry set and clear
    do_reset(1);
    rom_mem[0]  = {OP_ADD, 4'd3};
    rom_mem[1]  = {OP_JMP, 4'd9};
    rom_mem[9]  = {OP_JNC, 4'd4};
    rom_mem[10] = {OP_NOP, 4'd0};
    carry_in = 1'b1;
    a3 = '{0, 1, 9, 4, 5, 6, 7, 8, 9, 10};
    c3 = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    for (int i = 0; i < 10; i++) push_exp(a3[i], c3[i][0]);
    run_prog(10, 2, req_n);
    @(negedge clk_cpu);
    check_eq("jnc_taken_pc",  int'(rom_addr),   11);
    check_eq("nop_carry_upd", int'(carry_flag), 1);

    // ---- 4: single step at pc=5, second pulse in EXEC ignored
    do_reset(1);
    carry_in = 1'b0;
    rom_mem[0] = {OP_JMP, 4'd5};
    rom_mem[5] = {OP_ADD, 4'd7};
    push_exp(0, 1'b0);
    run_prog(1, 0, req_n);
    @(negedge clk_cpu);
    check_eq("step_pc_start", int'(rom_addr), 5);
    push_exp(5, 1'b0);
    step_once(8, 1'b1, n_exec, req_n, ack_cyc, exec_cyc);
    check_eq("step_exec_n", n_exec,             1);
    check_eq("step_pc",     int'(rom_addr),     6);
    check_eq("step_state",  int'(state_out),    0);

    // ---- 5: three wait cycles before ack
    ack_delay = 3;
    rom_mem[6] = 8'hA5;
    push_exp(6, 1'b0);
    step_once(10, 1'b0, n_exec, req_n, ack_cyc, exec_cyc);
    check_eq("wait_req_cycles", req_n,              4);
    check_eq("wait_exec_lat",   exec_cyc - ack_cyc, 1);
    check_eq("wait_exec_n",     n_exec,             1);

    // ---- 6a: timeout -> sticky FAULT at pc=7
    ack_delay = 1000;
    run = 1'b1;
    req_n = 0; cyc = 0;
    while (!fault && cyc < 30) begin
      @(negedge clk_cpu);
      cyc++;
      if (rom_req) req_n++;
    end
    check_eq("tmo_fault",      int'(fault),     1);
    check_eq("tmo_req_cycles", req_n,           ROM_TIMEOUT);
    check_eq("tmo_state",      int'(state_out), 3);
    check_eq("tmo_rom_req",    int'(rom_req),   0);
    repeat (10) @(negedge clk_cpu);
    check_eq("tmo_sticky",  int'(fault),     1);
    check_eq("tmo_state2",  int'(state_out), 3);
    check_eq("tmo_pc_hold", int'(rom_addr),  7);
    check_eq("tmo_exec_en", int'(exec_en),   0);
    run = 1'b0;

    // ---- 6b: ack on the last allowed cycle completes the fetch
    do_reset(1);
    ack_delay = ROM_TIMEOUT - 1;
    push_exp(0, 1'b0);
    run_prog(1, 0, req_n);
    check_eq("late_ack_req_cycles", req_n, ROM_TIMEOUT);
    @(negedge clk_cpu);
    check_eq("late_ack_no_fault", int'(fault),    0);
    check_eq("late_ack_pc",       int'(rom_addr), 5);

    // ---- 6c: reset mid-FETCH, late ack ignored
    ack_delay = 1000;
    run = 1'b1;
    repeat (3) @(negedge clk_cpu);
    check_eq("midf_in_fetch", int'(state_out), 1);
    reset = 1'b1; ack_force = 1'b1;
    @(negedge clk_cpu);
    check_eq("midf_state",   int'(state_out), 0);
    check_eq("midf_rom_req", int'(rom_req),   0);
    check_eq("midf_pc",      int'(rom_addr),  0);
    check_eq("midf_op",      int'(op_out),    int'(OP_NOP));
    run = 1'b0;
    reset = 1'b0;
    @(negedge clk_cpu);
    check_eq("idle_ack_op",    int'(op_out),    int'(OP_NOP));
    check_eq("idle_ack_state", int'(state_out), 0);
    ack_force = 1'b0;
    repeat (2) @(negedge clk_cpu);

    check_eq("sb_leftover", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
